monsopc_sram_tester: RTL

Avalon-MM master that exercises the on-chip SRAM slave in the monsopc system. It fills a word range with a seed-derived pattern, reads the range back, and compares each word. It reports the error count and the first failing word. The SRAM slave port connects directly to it as a fixed read-latency-1 responder. It is used for post-configuration memory self-test and for bench verification of the SRAM path.

---
 rtl/monsopc_sram_tester.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/monsopc_sram_tester.sv
// Avalon-MM SRAM self-test master: fills a word range with seed^address,
// reads it back through a latency-1 slave and reports mismatch statistics.
module monsopc_sram_tester #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 5000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base,
    input  logic [ADDR_W-1:0]   count,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   first_err_data,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic [DATA_W-1:0]   m_readdata,
    output logic                m_clken
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic              start_acc;
    logic              last_word;
    logic [ADDR_W-1:0] wcnt;
    logic [ADDR_W-1:0] addr_p0;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] seed_q;
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic              mismatch_p1;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(DEPTH - 1))
            return '0;
        else
            return a + ADDR_W'(1);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                  input logic [ADDR_W-1:0] a);
        return s ^ DATA_W'(a);
    endfunction

    assign last_word = (wcnt == ADDR_W'(1));

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = (count == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: if (last_word) state_nxt = S_READ;
            S_READ:  if (last_word) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
        m_chipselect = (state == S_WRITE) || (state == S_READ);
        m_write      = (state == S_WRITE);
        m_address    = m_chipselect ? addr_p0 : '0;
        m_writedata  = m_write ? pattern(seed_q, addr_p0) : '0;
        m_byteenable = '1;
        m_clken      = ~reset;
    end

    assign mismatch_p1 = vld_p1 && (m_readdata != pattern(seed_q, addr_p1));

    // Stage p0: state, word counter and bus address
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            done  <= 1'b0;
            wcnt  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            done   <= (state == S_DONE) && !start_acc;
            vld_p1 <= (state == S_READ);
            if (start_acc)
                wcnt <= count;
            else if (state == S_WRITE && last_word)
                wcnt <= cnt_q;
            else if (state == S_WRITE || state == S_READ)
                wcnt <= wcnt - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start_acc) begin
            base_q  <= base;
            cnt_q   <= count;
            seed_q  <= seed;
            addr_p0 <= base;
        end else if (state == S_WRITE && last_word) begin
            addr_p0 <= base_q;
        end else if (state == S_WRITE || state == S_READ) begin
            addr_p0 <= addr_inc(addr_p0);
        end
        addr_p1 <= addr_p0;
    end

    // Stage p1: compare returned data against the expected pattern
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (start_acc) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (mismatch_p1) begin
            err_count <= sat_inc(err_count);
            if (err_count == 16'd0) begin
                first_err_addr <= addr_p1;
                first_err_data <= m_readdata;
            end
        end
    end

endmodule
